// File: rtl/pll_lock_ce_gen.sv
// pll_lock_ce_gen
//   Qualifies the system PLL lock, sequences the arcade core reset and
//   produces the pixel / CPU / sound clock enables on clk_sys.
//
//   Lock handling: pll_locked is double-flopped into clk_sys. The lock must
//   stay high for LOCK_STABLE_CYCLES consecutive cycles before reset
//   sequencing starts. core_reset is then held for RESET_HOLD_CYCLES with the
//   enables already running, so the core's synchronous reset sees them.
//   Losing lock anywhere returns to WAIT. Losing it while in RUN also sets the
//   sticky lock_lost flag.
//
//   Optional build macro: CE_PAUSE_EN adds the pause input. While pause is
//   registered high in RUN, it silences ce_cpu and ce_snd without disturbing
//   their phase.
//
// Ports
//   clk_sys     in   PLL output clock
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   PLL lock, asynchronous to clk_sys
//   soft_reset  in   synchronous core reset request (honoured in HOLD/RUN)
//   pause       in   (CE_PAUSE_EN only) freeze CPU/sound enables in RUN
//   core_reset  out  active-high core reset, low only in RUN
//   core_run    out  high only in RUN
//   ce_pix      out  one-cycle pulse every PIX_DIV cycles
//   ce_cpu      out  one-cycle pulse every CPU_DIV cycles
//   ce_snd      out  one-cycle pulse every SND_DIV cycles
//   lock_lost   out  sticky lock-loss-in-RUN flag, cleared only by rst_n
module pll_lock_ce_gen #(
   parameter int LOCK_STABLE_CYCLES = 4096,
   parameter int RESET_HOLD_CYCLES  = 64,
   parameter int PIX_DIV            = 8,
   parameter int CPU_DIV            = 16,
   parameter int SND_DIV            = 8
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic pll_locked,
   input  logic soft_reset,
`ifdef CE_PAUSE_EN
   input  logic pause,
`endif
   output logic core_reset,
   output logic core_run,
   output logic ce_pix,
   output logic ce_cpu,
   output logic ce_snd,
   output logic lock_lost
);

   localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int HW = (RESET_HOLD_CYCLES > 1)  ? $clog2(RESET_HOLD_CYCLES)  : 1;
   localparam int PW = $clog2(PIX_DIV);
   localparam int CW = $clog2(CPU_DIV);
   localparam int NW = $clog2(SND_DIV);

   localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
   localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_DIV - 1);
   localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DIV - 1);
   localparam logic [NW-1:0] SND_LAST  = NW'(SND_DIV - 1);

   typedef enum logic [1:0] {WAIT, STABLE, HOLD, RUN} state_t;

   state_t        state, state_nxt;
   logic          lock_s1, locked_s;
   logic [SW-1:0] stab_cnt;
   logic [HW-1:0] hold_cnt;
   logic [PW-1:0] pix_cnt;
   logic [CW-1:0] cpu_cnt;
   logic [NW-1:0] snd_cnt;
   logic          lost_set;
   logic          div_clr;
   logic          div_run;
   logic          div_act;
   logic          gate;

   // two-flop synchroniser for the asynchronous lock
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         lock_s1  <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         lock_s1  <= pll_locked;
         locked_s <= lock_s1;
      end
   end

   // next state; a dropped lock beats soft_reset and count completion
   always_comb begin
      state_nxt = state;
      lost_set  = 1'b0;
      div_clr   = 1'b0;
      if (!locked_s) begin
         state_nxt = WAIT;
         lost_set  = (state == RUN);
      end else begin
         case (state)
            WAIT:   state_nxt = STABLE;
            STABLE: if (stab_cnt == STAB_LAST) begin
                       state_nxt = HOLD;
                       div_clr   = 1'b1;
                    end
            HOLD:   if (!soft_reset && hold_cnt == HOLD_LAST) state_nxt = RUN;
            RUN:    if (soft_reset) state_nxt = HOLD;
            default: state_nxt = WAIT;
         endcase
      end
   end

   // dividers run whenever the next state is HOLD/RUN, except on the cycle
   // that enters HOLD from STABLE so every enable starts from phase 0
   assign div_run = ((state_nxt == HOLD) || (state_nxt == RUN)) && !div_clr;
   assign div_act = (state == HOLD) || (state == RUN);

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state     <= WAIT;
         stab_cnt  <= '0;
         hold_cnt  <= '0;
         pix_cnt   <= '0;
         cpu_cnt   <= '0;
         snd_cnt   <= '0;
         lock_lost <= 1'b0;
      end else begin
         state    <= state_nxt;
         stab_cnt <= (state == STABLE && state_nxt == STABLE) ? stab_cnt + SW'(1) : '0;
         // soft_reset inside HOLD restarts the hold window
         hold_cnt <= (state == HOLD && state_nxt == HOLD && !soft_reset) ? hold_cnt + HW'(1) : '0;
         if (!div_run) begin
            pix_cnt <= '0;
            cpu_cnt <= '0;
            snd_cnt <= '0;
         end else begin
            pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PW'(1);
            cpu_cnt <= (cpu_cnt == CPU_LAST) ? '0 : cpu_cnt + CW'(1);
            snd_cnt <= (snd_cnt == SND_LAST) ? '0 : snd_cnt + NW'(1);
         end
         if (lost_set) lock_lost <= 1'b1;
      end
   end

`ifdef CE_PAUSE_EN
   // registered so there is no input-to-output combinational path
   logic pause_q;
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) pause_q <= 1'b0;
      else        pause_q <= pause;
   end
   assign gate = pause_q && (state == RUN);
`else
   assign gate = 1'b0;
`endif

   assign core_reset = (state != RUN);
   assign core_run   = (state == RUN);
   assign ce_pix     = div_act && (pix_cnt == PIX_LAST);
   assign ce_cpu     = div_act && (cpu_cnt == CPU_LAST) && !gate;
   assign ce_snd     = div_act && (snd_cnt == SND_LAST) && !gate;

endmodule
